// File: rtl/e203_exu_bjp_resolve.sv
// rtl/e203_exu_bjp_resolve.sv - EXU branch/jump resolve, IFU redirect and perf counters
//
// Purpose: checks the IFU static prediction of each executed branch/jump
// against its real outcome, computes the correct next PC and holds a flush
// request towards the IFU until it is acknowledged. Also counts resolved and
// mispredicted branches with saturating counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bjp_i_*               resolved branch offer (valid/ready handshake)
//   excp_kill             higher-priority pipeline flush
//   res_valid/res_mispred one-cycle resolve pulse and its mispredict flag
//   flush_req/flush_pc    redirect request to the IFU, flush_ack accepts it
//   cnt_clr               synchronous clear of both counters
//   bjp_cnt/mispred_cnt   accepted / mispredicted branch counters
module e203_exu_bjp_resolve #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bjp_i_valid,
  output logic               bjp_i_ready,
  input  logic [PC_SIZE-1:0] bjp_i_pc,
  input  logic [XLEN-1:0]    bjp_i_imm,
  input  logic               bjp_i_rv32,
  input  logic               bjp_i_jal,
  input  logic               bjp_i_jalr,
  input  logic               bjp_i_bxx,
  input  logic               bjp_i_cmp_res,
  input  logic [XLEN-1:0]    bjp_i_rs1,
  input  logic               bjp_i_prdt_taken,
  input  logic [PC_SIZE-1:0] bjp_i_prdt_pc,
  input  logic               excp_kill,
  output logic               res_valid,
  output logic               res_mispred,
  output logic               flush_req,
  output logic [PC_SIZE-1:0] flush_pc,
  input  logic               flush_ack,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   bjp_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]         state;
  logic               accept;
  logic [PC_SIZE-1:0] seq_pc;
  logic [PC_SIZE-1:0] br_tgt;
  logic [XLEN-1:0]    jalr_sum;
  logic [PC_SIZE-1:0] jalr_tgt;
  logic               mispred;
  logic [PC_SIZE-1:0] cor_pc;

  assign bjp_i_ready = (state == IDLE) & ~excp_kill;
  assign accept      = bjp_i_valid & bjp_i_ready;
  // The request is exactly the FLUSH state, so it is stable until ack/kill.
  assign flush_req   = (state == FLUSH);

  assign seq_pc   = bjp_i_pc + (bjp_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
  assign br_tgt   = bjp_i_pc + bjp_i_imm[PC_SIZE-1:0];
  assign jalr_sum = bjp_i_rs1 + bjp_i_imm;
  assign jalr_tgt = {jalr_sum[PC_SIZE-1:1], 1'b0};

  // JAL target is fully known at fetch, so it can never be mispredicted.
  // JALR is checked against the real target because the IFU may have used a
  // stale base register.
  always_comb begin
    mispred = 1'b0;
    cor_pc  = seq_pc;
    if (bjp_i_jalr) begin
      mispred = ~bjp_i_prdt_taken | (bjp_i_prdt_pc != jalr_tgt);
      cor_pc  = jalr_tgt;
    end else if (bjp_i_bxx) begin
      mispred = (bjp_i_prdt_taken != bjp_i_cmp_res);
      cor_pc  = bjp_i_cmp_res ? br_tgt : seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_pc    <= '0;
      res_valid   <= 1'b0;
      res_mispred <= 1'b0;
    end else begin
      res_valid   <= accept;
      res_mispred <= accept & mispred;
      if (state == FLUSH) begin
        // Kill and ack both end the redirect; kill simply drops it.
        if (excp_kill | flush_ack) state <= IDLE;
      end else if (accept & mispred) begin
        state    <= FLUSH;
        flush_pc <= cor_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bjp_cnt     <= '0;
      mispred_cnt <= '0;
    end else if (cnt_clr) begin
      bjp_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (accept & ~&bjp_cnt)               bjp_cnt     <= bjp_cnt + CNT_W'(1);
      if (accept & mispred & ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
